// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART transmit path.
//   txState_e        : frame sequencer state encoding
//   NOPARITY00/ODD/EVEN/NOPARITY11 : parity_type field values
//   STOP_ONE/STOP_TWO : stop_bits field values
//   hasParity()      : true when a parity_type value inserts a parity bit
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      WAIT   = 3'd1,
      START  = 3'd2,
      DATA   = 3'd3,
      PARITY = 3'd4,
      STOP   = 3'd5
   } txState_e;

   localparam logic [1:0] NOPARITY00 = 2'b00;
   localparam logic [1:0] ODD        = 2'b01;
   localparam logic [1:0] EVEN       = 2'b10;
   localparam logic [1:0] NOPARITY11 = 2'b11;

   localparam logic STOP_ONE = 1'b0;
   localparam logic STOP_TWO = 1'b1;

   // Both 00 and 11 mean "no parity", so only the two middle codes add a bit.
   function automatic logic hasParity(input logic [1:0] parityType);
      return (parityType == ODD) || (parityType == EVEN);
   endfunction

endpackage

// File: rtl/tx_frame_sequencer_parity.sv
// Parity
// Combinational parity generator for one payload byte.
//   dataByte_i   : byte to protect
//   parityType_i : parity_type code (00/11 none, 01 odd, 10 even)
//   parityBit_o  : bit to place on the line in the parity slot
module Parity
   import uart_pkg::*;
(
   input  logic [7:0] dataByte_i,
   input  logic [1:0] parityType_i,
   output logic       parityBit_o
);

   // Odd parity makes the total count of ones odd, hence the XNOR reduction;
   // even parity uses the plain XOR reduction. No-parity codes give 0.
   always_comb begin
      parityBit_o = 1'b0;
      case (parityType_i)
         ODD:     parityBit_o = ~^dataByte_i;
         EVEN:    parityBit_o = ^dataByte_i;
         default: parityBit_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/tx_frame_sequencer.sv
// tx_frame_sequencer
// Serialises one byte per accepted request into a UART frame:
// WAIT (line high until the first baud tick), start bit, 8 data bits LSB
// first, optional parity bit, then one or two stop bits.
//   clock       : system clock, rising edge
//   reset_n     : synchronous active-low reset
//   baud_tick   : one-cycle pulse per bit period
//   tx_valid    : requester has a byte
//   tx_data     : byte to send, captured at accept
//   parity_type : 00/11 none, 01 odd, 10 even, captured at accept
//   stop_bits   : 0 one stop bit, 1 two stop bits, captured at accept
//   tx_ready    : sequencer idle and out of reset, can accept
//   tx_serial   : registered serial line, idles high
//   tx_active   : frame in progress
//   tx_done     : one-cycle pulse in the first idle cycle after a frame
module tx_frame_sequencer
   import uart_pkg::*;
#(
   parameter int DATA_BITS = 8
)(
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 baud_tick,
   input  logic                 tx_valid,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic [1:0]           parity_type,
   input  logic                 stop_bits,
   output logic                 tx_ready,
   output logic                 tx_serial,
   output logic                 tx_active,
   output logic                 tx_done
);

   localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

   txState_e             state_q, state_d;
   logic [2:0]           bitIdx_q, bitIdx_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic [1:0]           parity_q, parity_d;
   logic                 stopBits_q, stopBits_d;
   logic                 done_q, done_d;
   logic                 serial_q, serial_d;
   logic                 parityBit;
   logic                 accept;

   // Parity is computed from the latched byte and type so that changes on
   // the request inputs mid-frame cannot disturb the frame in progress.
   Parity uParity (
      .dataByte_i   (data_q),
      .parityType_i (parity_q),
      .parityBit_o  (parityBit)
   );

   assign tx_ready  = (state_q == IDLE) && reset_n;
   assign accept    = tx_valid && tx_ready;
   assign tx_active = (state_q != IDLE);
   assign tx_done   = done_q;
   assign tx_serial = serial_q;

   // Next-state logic and the line value for the current state. In IDLE the
   // baud tick is irrelevant, so a tick that coincides with accept is never
   // counted and WAIT always lasts until a later tick. The bit index doubles
   // as the stop-bit counter, since it is free once DATA is finished.
   always_comb begin
      state_d    = state_q;
      bitIdx_d   = bitIdx_q;
      data_d     = data_q;
      parity_d   = parity_q;
      stopBits_d = stopBits_q;
      done_d     = 1'b0;
      serial_d   = 1'b1;

      case (state_q)
         IDLE: begin
            if (accept) begin
               data_d     = tx_data;
               parity_d   = parity_type;
               stopBits_d = stop_bits;
               bitIdx_d   = 3'd0;
               state_d    = WAIT;
            end
         end
         WAIT: begin
            if (baud_tick) begin
               state_d = START;
            end
         end
         START: begin
            serial_d = 1'b0;
            if (baud_tick) begin
               bitIdx_d = 3'd0;
               state_d  = DATA;
            end
         end
         DATA: begin
            serial_d = data_q[bitIdx_q];
            if (baud_tick) begin
               if (bitIdx_q == LAST_IDX) begin
                  bitIdx_d = 3'd0;
                  state_d  = hasParity(parity_q) ? PARITY : STOP;
               end else begin
                  bitIdx_d = bitIdx_q + 3'd1;
               end
            end
         end
         PARITY: begin
            serial_d = parityBit;
            if (baud_tick) begin
               bitIdx_d = 3'd0;
               state_d  = STOP;
            end
         end
         STOP: begin
            if (baud_tick) begin
               if ((stopBits_q == STOP_TWO) && (bitIdx_q == 3'd0)) begin
                  bitIdx_d = 3'd1;
               end else begin
                  bitIdx_d = 3'd0;
                  done_d   = 1'b1;
                  state_d  = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, counter, latched request and completion pulse. Reset clears the
   // pulse too, so an aborted frame never reports completion.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         bitIdx_q   <= 3'd0;
         data_q     <= '0;
         parity_q   <= 2'b00;
         stopBits_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         bitIdx_q   <= bitIdx_d;
         data_q     <= data_d;
         parity_q   <= parity_d;
         stopBits_q <= stopBits_d;
         done_q     <= done_d;
      end
   end

   // The line is registered from the current state, so it follows each
   // state or index change one clock later and is glitch-free.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         serial_q <= 1'b1;
      end else begin
         serial_q <= serial_d;
      end
   end

endmodule

// File: tb/tb_tx_frame_sequencer.sv
// tb_tx_frame_sequencer
// Directed bench for tx_frame_sequencer. Inputs are driven and outputs are
// sampled on the falling clock edge. Each bit slot is sampled three cycles
// after the baud tick that starts it.
module tb_tx_frame_sequencer;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       baud_tick;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic [1:0] parity_type;
   logic       stop_bits;
   logic       tx_ready;
   logic       tx_serial;
   logic       tx_active;
   logic       tx_done;

   int checks    = 0;
   int failures  = 0;
   int doneCount = 0;

   logic [15:0] expBits;

   tx_frame_sequencer #(.DATA_BITS(8)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .baud_tick   (baud_tick),
      .tx_valid    (tx_valid),
      .tx_data     (tx_data),
      .parity_type (parity_type),
      .stop_bits   (stop_bits),
      .tx_ready    (tx_ready),
      .tx_serial   (tx_serial),
      .tx_active   (tx_active),
      .tx_done     (tx_done)
   );

   // Free-running 10-unit clock.
   always #5 clock = ~clock;

   // Count completion pulses across the whole run.
   always @(negedge clock) begin
      if (tx_done) doneCount++;
   end

   task automatic checkOutput(input string tag, input logic observed, input logic expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
      end
   endtask

   task automatic checkCount(input string tag, input int observed, input int expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // One baud tick, then wait until three cycles in and sample there.
   task automatic applyStimulus();
      baud_tick = 1'b1;
      @(negedge clock);
      baud_tick = 1'b0;
      @(negedge clock);
      @(negedge clock);
   endtask

   // Present a request and let it be accepted at the next rising edge.
   task automatic acceptFrame(input logic [7:0] data, input logic [1:0] ptype,
                              input logic stops, input logic holdValid, input string tag);
      tx_data     = data;
      parity_type = ptype;
      stop_bits   = stops;
      tx_valid    = 1'b1;
      @(negedge clock);
      if (!holdValid) tx_valid = 1'b0;
      checkOutput({tag, "_wait_ready"},  tx_ready,  1'b0);
      checkOutput({tag, "_wait_active"}, tx_active, 1'b1);
      checkOutput({tag, "_wait_line"},   tx_serial, 1'b1);
   endtask

   // Tick through n bit slots, comparing the line with expBits LSB first.
   task automatic runBits(input logic [15:0] exp, input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         applyStimulus();
         checkOutput($sformatf("%s_bit%0d", tag, i), tx_serial, exp[i]);
         checkOutput($sformatf("%s_act%0d", tag, i), tx_active, 1'b1);
      end
   endtask

   // Final tick ending the last stop bit: done pulses for exactly one cycle.
   task automatic endFrame(input string tag);
      baud_tick = 1'b1;
      @(negedge clock);
      baud_tick = 1'b0;
      checkOutput({tag, "_done"},   tx_done,   1'b1);
      checkOutput({tag, "_ready"},  tx_ready,  1'b1);
      checkOutput({tag, "_idle"},   tx_active, 1'b0);
      checkOutput({tag, "_line"},   tx_serial, 1'b1);
      @(negedge clock);
      checkOutput({tag, "_done_once"}, tx_done, 1'b0);
   endtask

   initial begin
      reset_n     = 1'b0;
      baud_tick   = 1'b0;
      tx_valid    = 1'b0;
      tx_data     = 8'h00;
      parity_type = 2'b00;
      stop_bits   = 1'b0;

      // Reset state.
      @(negedge clock);
      @(negedge clock);
      checkOutput("rst_ready",  tx_ready,  1'b0);
      checkOutput("rst_line",   tx_serial, 1'b1);
      checkOutput("rst_active", tx_active, 1'b0);
      checkOutput("rst_done",   tx_done,   1'b0);
      reset_n = 1'b1;
      @(negedge clock);
      checkOutput("rst_release_ready", tx_ready, 1'b1);

      // Scenario 1: 0x55, even parity (four ones -> 0), one stop bit.
      acceptFrame(8'h55, 2'b10, 1'b0, 1'b0, "s1");
      expBits = {1'b1, 1'b0, 8'h55, 1'b0};
      runBits(expBits, 11, "s1");
      endFrame("s1");
      checkCount("s1_done_count", doneCount, 1);

      // Scenario 2: 0x80, odd parity (one one -> 0), two stop bits.
      // Request inputs are changed mid-frame and must be ignored.
      acceptFrame(8'h80, 2'b01, 1'b1, 1'b0, "s2");
      tx_data     = 8'hFF;
      parity_type = 2'b10;
      stop_bits   = 1'b0;
      expBits = {2'b11, 1'b0, 8'h80, 1'b0};
      runBits(expBits, 12, "s2");
      endFrame("s2");
      checkCount("s2_done_count", doneCount, 2);

      // Scenario 3: 0xA5, parity_type 11 means no parity bit.
      acceptFrame(8'hA5, 2'b11, 1'b0, 1'b0, "s3");
      expBits = {1'b1, 8'hA5, 1'b0};
      runBits(expBits, 10, "s3");
      endFrame("s3");
      checkCount("s3_done_count", doneCount, 3);

      // Scenario 4: reset while data bit 3 is on the line.
      acceptFrame(8'h00, 2'b00, 1'b0, 1'b0, "s4");
      expBits = {4'b0000, 1'b0};
      runBits(expBits, 5, "s4");
      reset_n = 1'b0;
      #1;
      checkOutput("s4_rst_ready", tx_ready, 1'b0);
      @(negedge clock);
      checkOutput("s4_rst_line",   tx_serial, 1'b1);
      checkOutput("s4_rst_active", tx_active, 1'b0);
      checkOutput("s4_rst_done",   tx_done,   1'b0);
      reset_n = 1'b1;
      @(negedge clock);
      checkOutput("s4_post_ready", tx_ready,  1'b1);
      checkOutput("s4_post_line",  tx_serial, 1'b1);
      applyStimulus();
      applyStimulus();
      checkOutput("s4_quiet_line",   tx_serial, 1'b1);
      checkOutput("s4_quiet_active", tx_active, 1'b0);
      checkCount("s4_done_count", doneCount, 3);

      // Scenario 5: tx_valid held high, 0x0F then 0xF0 back to back.
      acceptFrame(8'h0F, 2'b00, 1'b0, 1'b1, "s5a");
      tx_data = 8'hF0;
      expBits = {1'b1, 8'h0F, 1'b0};
      runBits(expBits, 10, "s5a");
      endFrame("s5a");
      checkOutput("s5b_wait_ready",  tx_ready,  1'b0);
      checkOutput("s5b_wait_active", tx_active, 1'b1);
      checkOutput("s5b_wait_line",   tx_serial, 1'b1);
      tx_valid = 1'b0;
      expBits = {1'b1, 8'hF0, 1'b0};
      runBits(expBits, 10, "s5b");
      endFrame("s5b");
      checkCount("s5_done_count", doneCount, 5);

      // Scenario 6: accept coincides with a baud tick; WAIT must hold.
      tx_data     = 8'h3C;
      parity_type = 2'b00;
      stop_bits   = 1'b0;
      tx_valid    = 1'b1;
      baud_tick   = 1'b1;
      @(negedge clock);
      tx_valid  = 1'b0;
      baud_tick = 1'b0;
      checkOutput("s6_wait_active", tx_active, 1'b1);
      checkOutput("s6_wait_line0",  tx_serial, 1'b1);
      @(negedge clock);
      @(negedge clock);
      checkOutput("s6_wait_line2",  tx_serial, 1'b1);
      expBits = {1'b1, 8'h3C, 1'b0};
      runBits(expBits, 10, "s6");
      endFrame("s6");
      checkCount("s6_done_count", doneCount, 6);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/tx_frame_sequencer.md
TX_FRAME_SEQUENCER -- requirements
Module: tx_frame_sequencer

Interface
REQ-001 Parameter: DATA_BITS, 8, payload bits per frame; the only supported value is 8.
REQ-002 Port: clock  input  1  system clock; all logic is on the rising edge.
REQ-003 Port: reset_n  input  1  synchronous, active-low reset.
REQ-004 Port: baud_tick  input  1  one-cycle pulse per bit period, from the baud generator.
REQ-005 Port: tx_valid  input  1  requester has a byte to send.
REQ-006 Port: tx_data  input  8  byte to send; sampled at accept.
REQ-007 Port: parity_type  input  2  00/11 none, 01 odd, 10 even; sampled at accept.
REQ-008 Port: stop_bits  input  1  0 means one stop bit, 1 means two; sampled at accept.
REQ-009 Port: tx_ready  output  1  sequencer can accept a byte.
REQ-010 Port: tx_serial  output  1  serial line; idles high.
REQ-011 Port: tx_active  output  1  a frame is in progress (any state other than IDLE).
REQ-012 Port: tx_done  output  1  one-cycle pulse marking frame completion.

Function
REQ-013 States SHALL be IDLE, WAIT, START, DATA, PARITY and STOP.
REQ-014 Accept SHALL occur when tx_valid and tx_ready are both high on a clock edge.
REQ-015 At accept, the sequencer SHALL latch tx_data, parity_type and stop_bits, and move IDLE -> WAIT.
REQ-016 tx_ready SHALL equal (state == IDLE) and reset_n; tx_valid outside IDLE SHALL be ignored.
REQ-017 WAIT -> START SHALL occur on the next baud_tick; tx_serial SHALL stay 1 during WAIT.
REQ-018 A baud_tick coincident with accept SHALL NOT be counted.
REQ-019 START SHALL drive 0 and move to DATA on the next baud_tick, so every bit lasts exactly one tick interval.
REQ-020 DATA SHALL drive latched bits LSB first, with a 3-bit index advancing per tick.
REQ-021 After bit 7's tick, DATA SHALL go to PARITY if the latched type is 01 or 10, otherwise to STOP.
REQ-022 PARITY SHALL drive the XNOR reduction of the data for odd and the XOR reduction for even, then go to STOP on the next tick.
REQ-023 STOP SHALL drive 1 for 1 or 2 ticks (per latched stop_bits), then enter IDLE.
REQ-024 tx_done SHALL pulse high for exactly the first IDLE cycle after STOP.
REQ-025 A new accept SHALL be legal in that same cycle (back-to-back frames).
REQ-026 tx_serial SHALL be registered, and SHALL update on the clock edge following each state or index change.
REQ-027 Changes to parity_type, stop_bits or tx_data mid-frame SHALL NOT affect the frame in progress.
REQ-028 Frame length in ticks SHALL be 1 (WAIT) + 1 + 8 + (0 or 1) + (1 or 2).

Reset
REQ-029 While reset_n is low at an edge, the block SHALL set state IDLE, tx_serial 1, tx_done 0, tx_active 0, bit index 0 and latched registers 0.
REQ-030 tx_ready SHALL be 0 while reset_n is low.
REQ-031 Reset mid-frame SHALL abort the frame, return the line high at the next edge and produce no tx_done.

Structure
REQ-032 Shared package uart_pkg SHALL hold:
- the state encoding typedef;
- parity-type constants NOPARITY00, ODD, EVEN, NOPARITY11;
- the stop-bit constants.
REQ-033 Sub-module: the sequencer SHALL instantiate the existing Parity unit on the latched byte and latched parity_type.
REQ-034 Parity's output SHALL be used only in the PARITY state.
REQ-035 The whole design SHALL be one always block for the state/counter registers plus one for tx_serial; it SHALL contain no latches.

Verification
REQ-036 Scenario 1: 0x55, even parity, 1 stop -> line 1(wait),0,1,0,1,0,1,0,1,0,0(parity),1; one tx_done; 12 ticks.
REQ-037 Scenario 2: 0x80, odd parity, 2 stop -> data 0,0,0,0,0,0,0,1; parity 0; stop 1,1; 13 ticks.
REQ-038 Scenario 3: 0xA5, parity_type 11 -> no parity bit; data 1,0,1,0,0,1,0,1; 11 ticks.
REQ-039 Scenario 4: reset_n low during data bit 3 -> tx_serial 1 and tx_ready 1 after reset release; no tx_done.
REQ-040 Scenario 5: tx_valid held high with bytes 0x0F then 0xF0 -> second accept in the tx_done cycle; no idle gap beyond WAIT; pulses of tx_valid mid-frame are ignored.
REQ-041 Scenario 6: tx_valid coincident with baud_tick -> WAIT persists until the next tick; start bit has full period.
